// File: rtl/debug_cmd_responder.sv
// Byte-level debug command responder: decodes host bytes and drives the CPU debug read ports
// and debug_enable. Optional inter-byte timeout is enabled by defining DEBUG_RESP_TIMEOUT_EN.
module debug_cmd_responder #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned D_ADDR_W       = 12,
  parameter int unsigned INST_W         = 16,
  parameter int unsigned I_ADDR_W       = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  output logic                debug_enable,
  output logic [3:0]          reg_debug_addr,
  input  logic [DATA_W-1:0]   reg_debug_rdata,
  output logic [D_ADDR_W-1:0] dmem_debug_addr,
  input  logic [DATA_W-1:0]   dmem_debug_rdata,
  output logic [I_ADDR_W-1:0] imem_debug_addr,
  input  logic [INST_W-1:0]   imem_debug_rdata,
  input  logic [I_ADDR_W-1:0] pc,
  output logic                rx_overrun
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, FETCH, SEND_HI, SEND_LO} state_t;
  typedef enum logic [1:0] {CMD_R, CMD_D, CMD_I} cmd_t;

  localparam logic [7:0] BYTE_R = 8'h52;
  localparam logic [7:0] BYTE_D = 8'h44;
  localparam logic [7:0] BYTE_I = 8'h49;
  localparam logic [7:0] BYTE_P = 8'h50;
  localparam logic [7:0] BYTE_H = 8'h48;
  localparam logic [7:0] BYTE_G = 8'h47;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  state_t     state;
  cmd_t       cmd;
  logic [7:0] addr_hi;
  logic [7:0] lo_byte;
  logic       fetch_cnt;

  logic [15:0] pc_ext;
  logic [15:0] inst_ext;
  logic        busy;

  assign pc_ext   = 16'(pc);
  assign inst_ext = 16'(imem_debug_rdata);
  assign busy     = (state == FETCH) || (state == SEND_HI) || (state == SEND_LO);

`ifdef DEBUG_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             in_addr;
  logic             timeout;

  assign in_addr = (state == ADDR_HI) || (state == ADDR_LO);
  assign timeout = in_addr && !rx_valid && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          idle_cnt <= '0;
    else if (rx_valid || !in_addr || timeout) idle_cnt <= '0;
    else                                   idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cmd             <= CMD_R;
      addr_hi         <= '0;
      lo_byte         <= '0;
      fetch_cnt       <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      debug_enable    <= 1'b0;
      reg_debug_addr  <= '0;
      dmem_debug_addr <= '0;
      imem_debug_addr <= '0;
      rx_overrun      <= 1'b0;
    end else begin
      if (rx_valid && busy) rx_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              BYTE_R: begin cmd <= CMD_R; state <= ADDR_LO; end
              BYTE_D: begin cmd <= CMD_D; state <= ADDR_HI; end
              BYTE_I: begin cmd <= CMD_I; state <= ADDR_HI; end
              BYTE_P: begin
                tx_valid <= 1'b1;
                tx_data  <= pc_ext[15:8];
                lo_byte  <= pc_ext[7:0];
                state    <= SEND_HI;
              end
              BYTE_H: begin
                debug_enable <= 1'b1;
                tx_valid     <= 1'b1;
                tx_data      <= ACK;
                state        <= SEND_LO;
              end
              BYTE_G: begin
                debug_enable <= 1'b0;
                tx_valid     <= 1'b1;
                tx_data      <= ACK;
                state        <= SEND_LO;
              end
              default: begin
                tx_valid <= 1'b1;
                tx_data  <= NAK;
                state    <= SEND_LO;
              end
            endcase
          end
        end
        ADDR_HI: begin
          if (rx_valid) begin
            addr_hi <= rx_data;
            state   <= ADDR_LO;
          end
`ifdef DEBUG_RESP_TIMEOUT_EN
          else if (timeout) state <= IDLE;
`endif
        end
        ADDR_LO: begin
          if (rx_valid) begin
            case (cmd)
              CMD_R:   reg_debug_addr  <= rx_data[3:0];
              CMD_D:   dmem_debug_addr <= D_ADDR_W'({addr_hi, rx_data});
              default: imem_debug_addr <= I_ADDR_W'({addr_hi, rx_data});
            endcase
            fetch_cnt <= 1'b0;
            state     <= FETCH;
          end
`ifdef DEBUG_RESP_TIMEOUT_EN
          else if (timeout) state <= IDLE;
`endif
        end
        FETCH: begin
          // first cycle lets the synchronous memory register the new address
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            fetch_cnt <= 1'b0;
            tx_valid  <= 1'b1;
            case (cmd)
              CMD_R: begin tx_data <= 8'(reg_debug_rdata);  state <= SEND_LO; end
              CMD_D: begin tx_data <= 8'(dmem_debug_rdata); state <= SEND_LO; end
              default: begin
                tx_data <= inst_ext[15:8];
                lo_byte <= inst_ext[7:0];
                state   <= SEND_HI;
              end
            endcase
          end
        end
        SEND_HI: begin
          if (tx_ready) begin
            tx_data <= lo_byte;
            state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_responder.sv
// Self-checking bench for debug_cmd_responder: table of command vectors plus directed
// timing/corner sequences; the timeout sequence runs only when DEBUG_RESP_TIMEOUT_EN is defined.
module tb_debug_cmd_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        debug_enable;
  logic [3:0]  reg_debug_addr;
  logic [7:0]  reg_debug_rdata;
  logic [11:0] dmem_debug_addr;
  logic [7:0]  dmem_debug_rdata;
  logic [11:0] imem_debug_addr;
  logic [15:0] imem_debug_rdata;
  logic [11:0] pc;
  logic        rx_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debug_cmd_responder #(
    .DATA_W(8), .D_ADDR_W(12), .INST_W(16), .I_ADDR_W(12), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .debug_enable(debug_enable),
    .reg_debug_addr(reg_debug_addr), .reg_debug_rdata(reg_debug_rdata),
    .dmem_debug_addr(dmem_debug_addr), .dmem_debug_rdata(dmem_debug_rdata),
    .imem_debug_addr(imem_debug_addr), .imem_debug_rdata(imem_debug_rdata),
    .pc(pc), .rx_overrun(rx_overrun)
  );

  // synchronous-read memory models
  logic [7:0]  regs [16];
  logic [7:0]  dmem [4096];
  logic [15:0] imem [4096];
  always @(posedge clk) begin
    reg_debug_rdata  <= regs[reg_debug_addr];
    dmem_debug_rdata <= dmem[dmem_debug_addr];
    imem_debug_rdata <= imem[imem_debug_addr];
  end

  typedef struct {
    logic [2:0][7:0] b;
    int              nb;
    logic [1:0][7:0] r;
    int              nr;
    logic            de;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] b0, b1, b2, input int nb,
                         input logic [7:0] r0, r1, input int nr, input logic de);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.nb = nb;
    v.r[0] = r0; v.r[1] = r1; v.nr = nr; v.de = de;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic collect(output int n, output logic [7:0] r0, output logic [7:0] r1);
    n = 0; r0 = '0; r1 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (n == 0) r0 = tx_data;
        else if (n == 1) r1 = tx_data;
        n++;
      end
    end
  endtask

  task automatic wait_tx(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  int         n;
  logic [7:0] r0, r1;

  initial begin
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; pc = 12'h3C4;
    for (int i = 0; i < 16; i++) regs[i] = 8'(8'h30 + i);
    for (int i = 0; i < 4096; i++) begin dmem[i] = 8'(i); imem[i] = 16'(i * 3); end
    dmem[12'h123] = 8'hA5;
    imem[12'hFFF] = 16'hBEEF;
    imem[12'h001] = 16'h1234;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst debug_enable", debug_enable, 0);
    check("rst reg_addr", reg_debug_addr, 0);
    check("rst dmem_addr", dmem_debug_addr, 0);
    check("rst imem_addr", imem_debug_addr, 0);
    check("rst rx_overrun", rx_overrun, 0);

    add_vec(8'h48, 8'h00, 8'h00, 1, 8'h06, 8'h00, 1, 1'b1);
    add_vec(8'h44, 8'h01, 8'h23, 3, 8'hA5, 8'h00, 1, 1'b1);
    add_vec(8'h47, 8'h00, 8'h00, 1, 8'h06, 8'h00, 1, 1'b0);
    add_vec(8'h44, 8'hF1, 8'h23, 3, 8'hA5, 8'h00, 1, 1'b0);
    add_vec(8'h52, 8'h05, 8'h00, 2, 8'h35, 8'h00, 1, 1'b0);
    add_vec(8'h52, 8'hF3, 8'h00, 2, 8'h33, 8'h00, 1, 1'b0);
    add_vec(8'h49, 8'h00, 8'h01, 3, 8'h12, 8'h34, 2, 1'b0);
    add_vec(8'h50, 8'h00, 8'h00, 1, 8'h03, 8'hC4, 2, 1'b0);
    add_vec(8'h7A, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, 1'b0);
    add_vec(8'h00, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].nb; k++) send_byte(vecs[i].b[k]);
      collect(n, r0, r1);
      check($sformatf("vec%0d count", i), n, vecs[i].nr);
      check($sformatf("vec%0d byte0", i), r0, vecs[i].r[0]);
      if (vecs[i].nr == 2) check($sformatf("vec%0d byte1", i), r1, vecs[i].r[1]);
      check($sformatf("vec%0d debug_enable", i), debug_enable, vecs[i].de);
    end

    // 'H' timing: debug_enable and reply appear one cycle after the byte
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h48;
    @(negedge clk);
    check("H de at N", debug_enable, 0);
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk);
    check("H de at N+1", debug_enable, 1);
    check("H tx_valid at N+1", tx_valid, 1);
    check("H tx_data", tx_data, 8'h06);
    @(negedge clk);
    check("H tx_valid drop", tx_valid, 0);

    // 'D' read latency: address at N+1, tx_valid at N+3
    send_byte(8'h44); send_byte(8'h01); send_byte(8'h23);
    @(negedge clk);
    check("D addr at N+1", dmem_debug_addr, 12'h123);
    check("D tx_valid N+1", tx_valid, 0);
    @(negedge clk);
    check("D tx_valid N+2", tx_valid, 0);
    @(negedge clk);
    check("D tx_valid N+3", tx_valid, 1);
    check("D tx_data N+3", tx_data, 8'hA5);
    @(negedge clk);
    check("D tx_valid drop", tx_valid, 0);

    // 'I' with backpressure: hi byte held, then lo byte
    tx_ready = 1'b0;
    send_byte(8'h49); send_byte(8'h0F); send_byte(8'hFF);
    check("I imem_addr", imem_debug_addr, 12'hFFF);
    wait_tx("I wait tx_valid");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("I hold valid %0d", i), tx_valid, 1);
      check($sformatf("I hold data %0d", i), tx_data, 8'hBE);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check("I lo valid", tx_valid, 1);
    check("I lo data", tx_data, 8'hEF);
    @(negedge clk);
    check("I end valid", tx_valid, 0);

    // byte during SEND_LO is dropped and flags overrun
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h05);
    wait_tx("R wait tx_valid");
    check("R data", tx_data, 8'h35);
    check("R overrun before", rx_overrun, 0);
    send_byte(8'h52);
    check("R overrun set", rx_overrun, 1);
    tx_ready = 1'b1;
    collect(n, r0, r1);
    check("R reply count", n, 1);
    check("R reply byte", r0, 8'h35);
    send_byte(8'h47);
    collect(n, r0, r1);
    check("post-drop G count", n, 1);
    check("post-drop G byte", r0, 8'h06);

    // byte coinciding with the final handshake is dropped
    tx_ready = 1'b0;
    send_byte(8'h7A);
    wait_tx("NAK wait tx_valid");
    check("NAK data", tx_data, 8'h15);
    @(posedge clk); #1;
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h48;
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk);
    check("coincident tx_valid", tx_valid, 0);
    check("coincident de", debug_enable, 0);
    collect(n, r0, r1);
    check("coincident no reply", n, 0);

    // reset mid-command aborts it
    send_byte(8'h48);
    collect(n, r0, r1);
    check("pre-reset de", debug_enable, 1);
    send_byte(8'h44); send_byte(8'h01);
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    check("midrst de", debug_enable, 0);
    check("midrst tx_valid", tx_valid, 0);
    check("midrst overrun", rx_overrun, 0);
    check("midrst dmem_addr", dmem_debug_addr, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    send_byte(8'h23);
    collect(n, r0, r1);
    check("post-rst count", n, 1);
    check("post-rst NAK", r0, 8'h15);

`ifdef DEBUG_RESP_TIMEOUT_EN
    send_byte(8'h44); send_byte(8'h01);
    n = 0;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    check("timeout no reply", n, 0);
    check("timeout dmem_addr held", dmem_debug_addr, 0);
    send_byte(8'h48);
    collect(n, r0, r1);
    check("timeout H count", n, 1);
    check("timeout H byte", r0, 8'h06);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_responder.md
# debug_cmd_responder

Byte-level debug command responder between the UART PHY and the CPU subsystem debug ports in the Basys3 FPGA build. It decodes host command bytes, drives the register, data-memory and instruction-memory debug read addresses plus `debug_enable`, and returns the read data as reply bytes on a valid/ready TX byte stream. The UART serializer and deserializer are separate blocks.

## Interface
Parameters:
- `DATA_W`, 8, data word width; reply is 1 byte.
- `D_ADDR_W`, 12, data-memory debug address width; at most 16.
- `INST_W`, 16, instruction width; reply is 2 bytes.
- `I_ADDR_W`, 12, instruction address and PC width; at most 16.
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte timeout. Used only with `DEBUG_RESP_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: async active-low reset.
- `rx_valid` in 1: one-cycle strobe, received byte; no backpressure.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: reply byte valid.
- `tx_data` out 8: reply byte.
- `tx_ready` in 1: PHY accepts byte when `tx_valid && tx_ready`.
- `debug_enable` out 1: CPU halt/debug request.
- `reg_debug_addr` out 4; `reg_debug_rdata` in DATA_W.
- `dmem_debug_addr` out D_ADDR_W; `dmem_debug_rdata` in DATA_W.
- `imem_debug_addr` out I_ADDR_W; `imem_debug_rdata` in INST_W.
- `pc` in I_ADDR_W: live program counter.
- `rx_overrun` out 1: sticky; set when a byte is dropped.

## Operation
- Commands:
  - `0x52` 'R' + 1 addr byte: `reg_debug_addr` = byte[3:0]. Reply is 1 byte.
  - `0x44` 'D' + addr hi + addr lo: `dmem_debug_addr` = {hi,lo}[D_ADDR_W-1:0]. Reply is 1 byte.
  - `0x49` 'I' + addr hi + addr lo: drives `imem_debug_addr`. Reply is `imem_debug_rdata`[15:8], then [7:0].
  - `0x50` 'P': `pc` is captured on the cycle the command byte is received. Reply is {pad,pc} hi byte, then lo byte; unused upper bits are zero.
  - `0x48` 'H': set `debug_enable`. Reply `0x06`.
  - `0x47` 'G': clear `debug_enable`. Reply `0x06`.
  - Any other byte in IDLE: reply `0x15` (NAK).
- Reads are allowed whether `debug_enable` is set or not; they return live contents.
- FSM states: IDLE, ADDR_HI, ADDR_LO, FETCH, SEND_HI, SEND_LO.
  - IDLE → ADDR_LO on 'R'.
  - IDLE → ADDR_HI on 'D' or 'I'.
  - IDLE → SEND_HI on 'P'.
  - IDLE → SEND_LO on 'H', 'G' or unknown byte.
  - ADDR_HI → ADDR_LO on the next byte.
  - ADDR_LO → FETCH on the next byte. The address register updates that cycle.
  - FETCH lasts 2 cycles (synchronous memory read), then latches rdata → SEND_HI for 'I', otherwise SEND_LO.
  - SEND_HI → SEND_LO on handshake.
  - SEND_LO → IDLE on handshake.
- Bytes arriving in FETCH, SEND_HI or SEND_LO are dropped and set `rx_overrun`. `rx_overrun` is cleared only by reset.
- Debug address outputs hold their last value between commands.

## Timing
- Reset values: state IDLE, `tx_valid`=0, `tx_data`=0, `debug_enable`=0, all debug addresses 0, `rx_overrun`=0.
- Read commands: the last addr byte arrives at cycle N. The address is visible at N+1. rdata is latched at end of N+2. `tx_valid` rises at N+3.
- 'P', 'H', 'G', NAK: the byte arrives at N; `tx_valid` rises at N+1.
- `debug_enable` changes at N+1 for 'H'/'G', independent of when the reply is accepted.
- `tx_valid` and `tx_data` are stable until the handshake.
  - Next byte of the same reply: `tx_valid` stays high, and `tx_data` changes the cycle after the handshake.
  - End of reply: `tx_valid` drops the cycle after the final handshake.
- An `rx_valid` in the same cycle as the final handshake is dropped (the state is still SEND_LO).
- Asserting `reset_n` mid-command aborts the command: no reply, `debug_enable` cleared.

## Configuration
- `DEBUG_RESP_TIMEOUT_EN` defined:
  - A counter reloads on every accepted `rx_valid`.
  - If it runs TIMEOUT_CYCLES while in ADDR_HI or ADDR_LO, the FSM returns to IDLE with no reply and no address update.
  - The counter does not run in other states.
- Macro undefined: no counter logic. The FSM waits indefinitely for address bytes.

## Test plan
- Reset, then 'H' (`0x48`) with `tx_ready`=1 → `debug_enable`=1 at N+1; single reply `0x06`. Then 'G' → `debug_enable`=0, reply `0x06`.
- 'D',`0x01`,`0x23` with memory model dmem[0x123]=`0xA5` → `dmem_debug_addr`=`0x123`; reply `0xA5` with `tx_valid` rising at N+3.
- 'I',`0x0F`,`0xFF`, imem[0xFFF]=`0xBEEF`, `tx_ready` low for 5 cycles → `0xBE` held stable, then `0xEF`.
- 'P' with pc=`0x3C4` → replies `0x03`, `0xC4`. Byte `0x7A` → reply `0x15`.
- 'R',`0x05` with an extra `rx_valid` (`0x52`) during SEND_LO → reply is r5 only; extra byte dropped; `rx_overrun`=1; FSM returns to IDLE.
- With `DEBUG_RESP_TIMEOUT_EN` and TIMEOUT_CYCLES=100: 'D',`0x01`, then idle 100 cycles → IDLE, no reply. Next 'H' → `0x06`.
